// File: rtl/i2c_master_ctrl.sv
// Bit-level I2C master: one START / address+RW / NBYTES data bytes / STOP transaction per request.
// state | meaning: IDLE wait | START start cond | ADDR addr+rw | ADDR_ACK/WR_ACK slave ack | WR_BYTE/RD_BYTE data | RD_ACK master ack | STOP stop cond
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int NB_W    = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENB,
    input  logic            START_TX,
    input  logic [6:0]      ADDR,
    input  logic            RW,
    input  logic [NB_W-1:0] NBYTES,
    input  logic [7:0]      TX_DATA,
    output logic            TX_REQ,
    output logic [7:0]      RX_DATA,
    output logic            RX_VALID,
    output logic            SCL,
    output logic            SDA_O,
    output logic            SDA_OE,
    input  logic            SDA_I,
    output logic            BUSY,
    output logic            DONE,
    output logic            NACK
);
    localparam int QW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_t;

    state_t          state;
    logic [QW-1:0]   qcnt;
    logic [1:0]      ph;
    logic [2:0]      bitc;
    logic [7:0]      shreg;
    logic [NB_W-1:0] cnt;
    logic            rw_r;
    logic            q;

    assign q = (qcnt == '0);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= S_IDLE;
            qcnt     <= '0;
            ph       <= '0;
            bitc     <= '0;
            shreg    <= '0;
            cnt      <= '0;
            rw_r     <= 1'b0;
            SCL      <= 1'b1;
            SDA_O    <= 1'b1;
            SDA_OE   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            TX_REQ   <= 1'b0;
            RX_VALID <= 1'b0;
            RX_DATA  <= '0;
            NACK     <= 1'b0;
        end else begin
            TX_REQ   <= 1'b0;
            RX_VALID <= 1'b0;
            DONE     <= 1'b0;
            if (ENB) begin
                qcnt <= q ? QW'(CLK_DIV - 1) : qcnt - 1'b1;
                if (state == S_IDLE) begin
                    if (START_TX) begin
                        rw_r  <= RW;
                        cnt   <= NBYTES;
                        shreg <= {ADDR, RW};
                        BUSY  <= 1'b1;
                        NACK  <= 1'b0;
                        ph    <= '0;
                        bitc  <= '0;
                        state <= S_START;
                    end
                end else if (q) begin
                    ph <= ph + 2'd1;
                    case (state)
                        S_START: begin
                            if (ph == 2'd0) begin
                                SDA_OE <= 1'b1;
                                SDA_O  <= 1'b0;
                            end else if (ph == 2'd2) begin
                                SCL   <= 1'b0;
                                ph    <= '0;
                                state <= S_ADDR;
                            end
                        end
                        S_STOP: begin
                            if (ph == 2'd0) begin
                                SCL    <= 1'b0;
                                SDA_OE <= 1'b1;
                                SDA_O  <= 1'b0;
                            end else if (ph == 2'd2) begin
                                SCL <= 1'b1;
                            end else if (ph == 2'd3) begin
                                SDA_OE <= 1'b0;
                                SDA_O  <= 1'b1;
                                DONE   <= 1'b1;
                                BUSY   <= 1'b0;
                                state  <= S_IDLE;
                            end
                        end
                        default: begin
                            if (ph == 2'd0) begin
                                SCL <= 1'b0;
                                case (state)
                                    S_ADDR, S_WR_BYTE: begin
                                        SDA_OE <= 1'b1;
                                        SDA_O  <= shreg[7];
                                    end
                                    S_RD_ACK: begin
                                        SDA_OE <= 1'b1;
                                        SDA_O  <= (cnt == NB_W'(1));
                                    end
                                    default: begin
                                        SDA_OE <= 1'b0;
                                        SDA_O  <= 1'b1;
                                    end
                                endcase
                            end else if (ph == 2'd2) begin
                                SCL <= 1'b1;
                            end else if (ph == 2'd3) begin
                                // End of slot: SDA_I has been stable for a full SCL-high quarter.
                                case (state)
                                    S_ADDR, S_WR_BYTE: begin
                                        shreg <= {shreg[6:0], 1'b0};
                                        bitc  <= bitc + 3'd1;
                                        if (bitc == 3'd7)
                                            state <= (state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                                    end
                                    S_ADDR_ACK: begin
                                        if (SDA_I) begin
                                            NACK  <= 1'b1;
                                            state <= S_STOP;
                                        end else if (cnt == '0) begin
                                            state <= S_STOP;
                                        end else if (rw_r) begin
                                            state <= S_RD_BYTE;
                                        end else begin
                                            shreg  <= TX_DATA;
                                            TX_REQ <= 1'b1;
                                            state  <= S_WR_BYTE;
                                        end
                                    end
                                    S_WR_ACK: begin
                                        if (SDA_I) begin
                                            NACK  <= 1'b1;
                                            state <= S_STOP;
                                        end else begin
                                            cnt <= cnt - 1'b1;
                                            if (cnt == NB_W'(1)) begin
                                                state <= S_STOP;
                                            end else begin
                                                shreg  <= TX_DATA;
                                                TX_REQ <= 1'b1;
                                                state  <= S_WR_BYTE;
                                            end
                                        end
                                    end
                                    S_RD_BYTE: begin
                                        shreg <= {shreg[6:0], SDA_I};
                                        bitc  <= bitc + 3'd1;
                                        if (bitc == 3'd7) begin
                                            RX_DATA  <= {shreg[6:0], SDA_I};
                                            RX_VALID <= 1'b1;
                                            state    <= S_RD_ACK;
                                        end
                                    end
                                    S_RD_ACK: begin
                                        cnt   <= cnt - 1'b1;
                                        state <= (cnt == NB_W'(1)) ? S_STOP : S_RD_BYTE;
                                    end
                                    default: state <= S_IDLE;
                                endcase
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule
